// File: rtl/alu_pkg.sv
// alu_pkg: ALUOperation encoding and FSM state type shared by the execution unit
package alu_pkg;
   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_NOR     = 4'b0010;
   localparam logic [3:0] ALU_ADD     = 4'b0011;
   localparam logic [3:0] ALU_SUB     = 4'b0100;
   localparam logic [3:0] ALU_LUI     = 4'b0101;
   localparam logic [3:0] ALU_SLL     = 4'b0110;
   localparam logic [3:0] ALU_SRL     = 4'b0111;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1001;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: 1-bit-per-cycle shifter with down-counter; value shows the contents after this cycle's step
module alu_serial_shifter #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   dir,
   input  logic [DATA_WIDTH-1:0]  load_value,
   input  logic [SHAMT_WIDTH-1:0] amount,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  value
);
   logic [DATA_WIDTH-1:0]  work;
   logic [SHAMT_WIDTH-1:0] count;
   logic                   dir_q;
   assign busy  = count != '0;
   assign done  = count == SHAMT_WIDTH'(1);
   assign value = busy ? (dir_q ? work >> 1 : work << 1) : work;
   // load operand and count, then step once per cycle until the count runs out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work  <= '0;
         count <= '0;
         dir_q <= 1'b0;
      end else if (load) begin
         work  <= load_value;
         count <= amount;
         dir_q <= dir;
      end else if (busy) begin
         work  <= value;
         count <= count - SHAMT_WIDTH'(1);
      end
   end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU, single-cycle logic/arith ops and iterative shifts
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             alu_operation,
   input  logic [DATA_WIDTH-1:0]  operand_a,
   input  logic [DATA_WIDTH-1:0]  operand_b,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  result,
   output logic                   zero,
   output logic                   overflow,
   output logic                   illegal_op
);
   localparam int H = DATA_WIDTH / 2;
   localparam int M = DATA_WIDTH - 1;
   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] sum, diff, res_c, sh_value;
   logic                  ovf_c, ill_c, is_shift, accept, load, sh_busy, sh_done, shift_end;
   assign sum       = operand_a + operand_b;
   assign diff      = operand_a - operand_b;
   assign is_shift  = alu_operation == ALU_SLL || alu_operation == ALU_SRL;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready;
   assign load      = accept && is_shift && shamt != '0;
   assign shift_end = sh_done || !sh_busy;
   alu_serial_shifter #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH)) u_shift (
      .clk(clk), .reset(reset), .load(load), .dir(alu_operation == ALU_SRL),
      .load_value(operand_b), .amount(shamt), .busy(sh_busy), .done(sh_done), .value(sh_value)
   );
   // single-cycle datapath; unknown or unlisted codes fall to the illegal default
   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      ill_c = 1'b0;
      case (alu_operation)
         ALU_AND: res_c = operand_a & operand_b;
         ALU_OR:  res_c = operand_a | operand_b;
         ALU_NOR: res_c = ~(operand_a | operand_b);
         ALU_ADD: begin
            res_c = sum;
            ovf_c = operand_a[M] == operand_b[M] && sum[M] != operand_a[M];
         end
         ALU_SUB: begin
            res_c = diff;
            ovf_c = operand_a[M] != operand_b[M] && diff[M] != operand_a[M];
         end
         ALU_LUI: res_c = {operand_b[H-1:0], {H{1'b0}}};
         ALU_SLL, ALU_SRL: res_c = operand_b;
         default: ill_c = 1'b1;
      endcase
   end
   // next-state: shifts with a nonzero amount detour through SHIFT
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? (load ? SHIFT : DONE) : IDLE;
         SHIFT:   state_n = shift_end ? DONE : SHIFT;
         DONE:    state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   // result and flags are captured once per operation and held through DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result     <= '0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         illegal_op <= 1'b0;
      end else if (accept && !load) begin
         result     <= res_c;
         zero       <= res_c == '0;
         overflow   <= ovf_c;
         illegal_op <= ill_c;
      end else if (state == SHIFT && shift_end) begin
         result     <= sh_value;
         zero       <= sh_value == '0;
         overflow   <= 1'b0;
         illegal_op <= 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: scoreboard bench with directed vectors for multicycle_alu
module tb_multicycle_alu;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, zero, overflow, illegal_op;
   logic [3:0]  alu_operation = 4'b0;
   logic [31:0] operand_a = '0, operand_b = '0, result;
   logic [4:0]  shamt = '0;
   typedef struct {
      logic [31:0] r;
      logic        z, o, i;
      int          lat, acc;
   } exp_t;
   exp_t        sb[$];
   exp_t        cur;
   int          checks = 0, errors = 0, cyc = 0;
   bit          seen = 1'b0;
   logic [34:0] held;

   multicycle_alu dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_operation(alu_operation), .operand_a(operand_a), .operand_b(operand_b),
      .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .overflow(overflow), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pop the oldest expectation when a result first appears, then require it to stay put
   always @(negedge clk) begin
      if (reset || !out_valid) seen = 1'b0;
      else if (!seen) begin
         seen = 1'b1;
         held = {result, zero, overflow, illegal_op};
         if (sb.size() == 0) chk("unexpected_result", 64'(result), 64'hDEAD_BEEF_0000_0000);
         else begin
            cur = sb.pop_front();
            chk("result", 64'(result), 64'(cur.r));
            chk("zero", 64'(zero), 64'(cur.z));
            chk("overflow", 64'(overflow), 64'(cur.o));
            chk("illegal_op", 64'(illegal_op), 64'(cur.i));
            chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
         end
      end else chk("hold_stable", 64'({result, zero, overflow, illegal_op}), 64'(held));
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic ez,
                        input logic eo, input logic ei, input int lat);
      for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
      if (!in_ready) begin
         chk("in_ready_timeout", 64'(in_ready), 64'd1);
         return;
      end
      alu_operation = op;
      operand_a     = a;
      operand_b     = b;
      shamt         = sh;
      in_valid      = 1'b1;
      sb.push_back('{er, ez, eo, ei, lat, cyc + 1});
      @(negedge clk);
      in_valid      = 1'b0;
      alu_operation = 4'b0011;
      operand_b     = 32'hFFFF_FFFF;
      shamt         = 5'd3;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && (sb.size() != 0 || !in_ready); n++) @(negedge clk);
      chk("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'({result, zero, overflow, illegal_op}), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      issue(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
      issue(4'b0100, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
      issue(4'b0101, 32'h0, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 1'b0, 1);
      issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1);
      issue(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1);
      issue(4'b0010, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1);
      issue(4'b0100, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
      issue(4'b1001, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
      issue(4'b1111, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
      issue(4'b0110, 32'hFFFF_FFFF, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32);
      chk("shift_in_ready_low", 64'(in_ready), 64'd0);
      chk("shift_out_valid_low", 64'(out_valid), 64'd0);
      issue(4'b0111, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 5);
      issue(4'b0111, 32'h0, 32'hFFFF_FFFF, 5'd31, 32'h1, 1'b0, 1'b0, 1'b0, 32);
      issue(4'b0110, 32'h0, 32'h0000_1234, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1);
      issue(4'b0110, 32'h0, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 2);
      drain();
      out_ready = 1'b0;
      issue(4'b0001, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1);
      for (int k = 0; k < 10; k++) begin
         chk("stall_in_ready_low", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("release_out_valid", 64'(out_valid), 64'd0);
      issue(4'b0011, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1);
      issue(4'b1001, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
      drain();
      issue(4'b0110, 32'h0, 32'h1, 5'd20, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 21);
      repeat (7) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'd0);
      chk("async_result", 64'(result), 64'd0);
      chk("async_flags", 64'({zero, overflow, illegal_op}), 64'd0);
      chk("async_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      issue(4'b0011, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Execution unit on the consumer end of the ALU-control interface. It accepts a 4-bit ALUOperation code plus operands through a valid/ready handshake. It computes the result and presents it with flags through a second valid/ready handshake. Logical, arithmetic and LUI ops complete in one cycle; SLL/SRL use an iterative 1-bit-per-cycle shifter, so the pipeline control tolerates variable latency.

Parameters:
DATA_WIDTH, 32, operand and result width (even, >= 2)
SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
alu_operation  input  4  ALUOperation code
operand_a  input  DATA_WIDTH  first operand (rs)
operand_b  input  DATA_WIDTH  second operand (rt / immediate; shift source)
shamt  input  SHAMT_WIDTH  shift amount
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  DATA_WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only)
illegal_op  output  1  unrecognised operation code

Behaviour:
- Op codes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, LUI 0101, SLL 0110, SRL 0111. Every other code (including 1001 default) is illegal: result 0, zero 1, overflow 0, illegal_op 1. An illegal op is still a single-cycle op.
- LUI: result = {operand_b[DATA_WIDTH/2-1:0], DATA_WIDTH/2 zeros}.
- SLL/SRL act on operand_b; operand_a is ignored. SRL is logical and zero-fills.
- ADD/SUB use modulo-2^DATA_WIDTH arithmetic.
  - ADD overflow = operands share a sign and the result sign differs.
  - SUB overflow = operand signs differ and the result sign differs from a.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). A transfer occurs on a clock edge with in_valid && in_ready; operands and op are latched at that edge.
- IDLE, on accept:
  - Non-shift op, or shift with shamt == 0: compute and register result/flags, go to DONE. out_valid is high the cycle after accept (latency 1).
  - Shift with shamt > 0: load the working register with operand_b and the counter with shamt, go to SHIFT.
- SHIFT: each cycle shift the working register by 1 in the op direction and decrement the counter. When the counter reaches 0, register the result and flags and go to DONE. Latency = 1 + shamt cycles (e.g. shamt 31 gives out_valid 32 cycles after accept).
- DONE: out_valid = 1. result/zero/overflow/illegal_op are held stable until out_valid && out_ready. On that edge go to IDLE, so the earliest next accept is the following cycle (no back-to-back overlap).
- out_valid is low in IDLE and SHIFT. Flag outputs are held at their last value outside DONE, and are only meaningful while out_valid = 1.
- Input changes while not in IDLE are ignored.
- Reset, asserted at any time including mid-shift or while DONE is stalled: state goes to IDLE immediately. result, counter and working register clear to 0; zero 0, overflow 0, illegal_op 0, out_valid 0. No partial result is ever presented.
- An X/unknown op code is treated as illegal; no latch inference.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams ALU_AND .. ALU_SRL and ALU_ILLEGAL = 4'b1001, matching the ALUOperation encoding driven by the control decoder;
  - FSM state encoding.
- One natural sub-module, alu_serial_shifter: working register and down-counter, with inputs load/dir/value/amount and outputs busy/done/value. The FSM and combinational datapath stay in multicycle_alu.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> after 1 cycle out_valid, result 0x80000000, overflow 1, zero 0.
- SUB a=5, b=5 -> result 0, zero 1, overflow 0. LUI b=0x0000ABCD -> result 0xABCD0000.
- SLL b=0x00000001, shamt=31 -> in_ready low for 31 SHIFT cycles; out_valid on cycle 32, result 0x80000000. SRL b=0x80000000, shamt=4 -> result 0x08000000 after 5 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready 0. Assert out_ready -> next cycle IDLE, new request accepted the cycle after.
- Illegal code 4'b1001 (and 4'b1111) -> result 0, zero 1, illegal_op 1, latency 1. NOR a=0, b=0 -> 0xFFFFFFFF.
- Reset asserted asynchronously mid-SHIFT (SLL shamt=20, after 7 cycles) -> out_valid, result and flags 0 without a clock edge. After release, in_ready = 1 and a fresh ADD 2+3 returns 5.
